// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control inputs and LED pattern outputs of led_pattern_gen
interface led_pattern_gen_if #(
  parameter int NUM_CH = 8,
  parameter int BAR_W  = 8,
  parameter int DIV_W  = 4
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic                    enable;
  logic                    clear;
  logic [1:0]              mode;
  logic [DIV_W-1:0]        step_div;
  logic                    led_clk;
  logic [PW-1:0]           pos;
  logic                    started;
  logic [NUM_CH*BAR_W-1:0] leds;
  modport master (output enable, clear, mode, step_div, input led_clk, pos, started, leds);
  modport slave  (input enable, clear, mode, step_div, output led_clk, pos, started, leds);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: comet-style LED bar pattern generator with led_clk strobe; define LED_PATTERN_FADE_EN for the fading tail
module led_pattern_gen #(
  parameter int NUM_CH      = 8,
  parameter int BAR_W       = 8,
  parameter int LED_CLK_DIV = 28,
  parameter int DIV_W       = 4
)(
  input logic              clk,
  input logic              nreset,
  led_pattern_gen_if.slave bus
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(LED_CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(NUM_CH - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [CW-1:0] LMAX = CW'(LED_CLK_DIV - 1);
  typedef enum logic [1:0] {BOUNCE, SWEEP_UP, SWEEP_DN, HOLD} mode_t;
  logic [CW-1:0]           r_lcnt;
  logic                    r_led_clk;
  logic [DIV_W-1:0]        r_scnt;
  logic [PW-1:0]           r_pos;
  logic [PW-1:0]           w_np;
  logic                    r_up;
  logic                    w_up;
  logic                    r_started;
  logic [NUM_CH*BAR_W-1:0] r_leds;
  logic [NUM_CH*BAR_W-1:0] w_leds;
  logic                    w_tick;
  mode_t                   w_mode;
  assign w_mode = mode_t'(bus.mode);
  assign w_tick = bus.enable && r_scnt >= bus.step_div;
  function automatic logic [BAR_W-1:0] seg(int i, int p);
`ifdef LED_PATTERN_FADE_EN
    int d;
    d = i > p ? i - p : p - i;
    return d < BAR_W ? {BAR_W{1'b1}} >> d : '0;
`else
    return i == p ? '1 : '0;
`endif
  endfunction
  // next peak position and direction for the coming tick
  always_comb begin
    w_np = r_pos;
    w_up = r_up;
    if (!r_started) w_np = w_mode == SWEEP_DN ? PMAX : '0;
    else if (NUM_CH > 1) case (w_mode)
      BOUNCE: begin
        w_up = r_up ? r_pos != PMAX : r_pos == '0;
        w_np = w_up ? r_pos + PONE : r_pos - PONE;
      end
      SWEEP_UP: begin
        w_np = r_pos == PMAX ? '0 : r_pos + PONE;
        w_up = 1'b1;
      end
      SWEEP_DN: begin
        w_np = r_pos == '0 ? PMAX : r_pos - PONE;
        w_up = 1'b0;
      end
      default: ;
    endcase
  end
  // bar image for the next peak position
  always_comb begin
    w_leds = '0;
    for (int i = 0; i < NUM_CH; i++) w_leds[i*BAR_W +: BAR_W] = seg(i, int'(w_np));
  end
  // free-running led_clk divider, untouched by clear/enable
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_lcnt    <= '0;
      r_led_clk <= 1'b0;
    end else begin
      r_led_clk <= r_lcnt == LMAX;
      r_lcnt    <= r_lcnt == LMAX ? '0 : r_lcnt + CW'(1);
    end
  end
  // step prescaler and pattern state; clear wins over a tick
  always_ff @(posedge clk) begin
    if (!nreset || bus.clear) begin
      r_scnt    <= '0;
      r_pos     <= '0;
      r_up      <= 1'b1;
      r_started <= 1'b0;
      r_leds    <= '0;
    end else begin
      if (bus.enable) r_scnt <= w_tick ? '0 : r_scnt + DIV_W'(1);
      if (w_tick) begin
        r_pos     <= w_np;
        r_up      <= w_up;
        r_started <= 1'b1;
        r_leds    <= w_leds;
      end
    end
  end
  assign bus.led_clk = r_led_clk;
  assign bus.pos     = r_pos;
  assign bus.started = r_started;
  assign bus.leds    = r_leds;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen plus directed pattern checks
module tb_led_pattern_gen;
  localparam int N = 8, W = 8, D = 28, DW = 4;
  typedef struct packed {
    logic        lclk;
    logic [2:0]  pos;
    logic        started;
    logic [63:0] leds;
  } exp_t;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;
  led_pattern_gen_if #(.NUM_CH(N), .BAR_W(W), .DIV_W(DW)) bus ();
  led_pattern_gen #(.NUM_CH(N), .BAR_W(W), .LED_CLK_DIV(D), .DIV_W(DW)) dut (
    .clk(clk), .nreset(nreset), .bus(bus)
  );
  exp_t q[$];
  int lclk_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_lclk = 0;
  int m_lcnt = 0, m_scnt = 0, m_pos = 0;
  bit m_lclk = 0, m_up = 1, m_started = 0;
  logic [63:0] m_leds = '0;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] fpat(int p);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int d = i > p ? i - p : p - i;
`ifdef LED_PATTERN_FADE_EN
      r[i*8 +: 8] = d < W ? 8'hFF >> d : 8'h00;
`else
      r[i*8 +: 8] = d == 0 ? 8'hFF : 8'h00;
`endif
    end
    return r;
  endfunction
  task automatic model();
    bit tick;
    exp_t e;
    if (!nreset) begin
      m_lcnt = 0; m_lclk = 0; m_scnt = 0; m_pos = 0; m_up = 1; m_started = 0; m_leds = '0;
    end else begin
      m_lclk = m_lcnt == D - 1;
      m_lcnt = (m_lcnt + 1) % D;
      tick = bus.enable && m_scnt >= int'(bus.step_div);
      if (bus.enable) m_scnt = tick ? 0 : m_scnt + 1;
      if (bus.clear) begin
        m_pos = 0; m_up = 1; m_started = 0; m_leds = '0; m_scnt = 0;
      end else if (tick) begin
        if (!m_started) begin
          m_started = 1;
          m_pos = bus.mode == 2 ? N - 1 : 0;
        end else case (bus.mode)
          0: begin
            if (m_up && m_pos == N - 1) m_up = 0;
            else if (!m_up && m_pos == 0) m_up = 1;
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
          end
          1: begin m_pos = (m_pos + 1) % N; m_up = 1; end
          2: begin m_pos = (m_pos + N - 1) % N; m_up = 0; end
          default: ;
        endcase
        m_leds = fpat(m_pos);
      end
    end
    e.lclk = m_lclk; e.pos = 3'(m_pos); e.started = m_started; e.leds = m_leds;
    q.push_back(e);
  endtask
  task automatic cycle(int n);
    exp_t e;
    repeat (n) begin
      model();
      @(posedge clk);
      #1;
      cyc++;
      e = q.pop_front();
      check("sb_lclk", bus.led_clk, e.lclk);
      check("sb_pos", bus.pos, e.pos);
      check("sb_started", bus.started, e.started);
      check("sb_leds", bus.leds, e.leds);
      if (bus.led_clk) begin
        lclk_q.push_back(cyc);
        if (last_lclk > 0) check("lclk_gap", cyc - last_lclk, D);
        last_lclk = cyc;
      end
    end
  endtask
  int bseq[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int upseq[3] = '{7, 0, 1};
  int dnseq[3] = '{0, 7, 6};
  initial begin
    bus.enable = 0; bus.clear = 0; bus.mode = 0; bus.step_div = 0;
    cycle(3);
    check("rst_pos", bus.pos, 0);
    check("rst_started", bus.started, 0);
    check("rst_leds", bus.leds, 0);
    nreset = 1;
    cyc = 0;
    cycle(90);
    check("lclk_count", lclk_q.size(), 3);
    for (int k = 0; k < 3 && k < lclk_q.size(); k++) check("lclk_at", lclk_q[k], D * (k + 1));
    check("idle_leds", bus.leds, 0);
    bus.mode = 0; bus.step_div = 3; bus.enable = 1;
    cycle(3);
    check("pre_tick_started", bus.started, 0);
    cycle(1);
    check("tick1_started", bus.started, 1);
    check("tick1_pos", bus.pos, 0);
`ifdef LED_PATTERN_FADE_EN
    check("tick1_leds", bus.leds, 64'h0103070F1F3F7FFF);
`else
    check("tick1_leds", bus.leds, 64'h00000000000000FF);
`endif
    cycle(4);
    check("tick2_pos", bus.pos, 1);
`ifdef LED_PATTERN_FADE_EN
    check("tick2_leds", bus.leds, 64'h03070F1F3F7FFF7F);
`else
    check("tick2_leds", bus.leds, 64'h000000000000FF00);
`endif
    bus.clear = 1;
    cycle(1);
    bus.clear = 0; bus.step_div = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1);
      check("bounce_pos", bus.pos, bseq[k]);
    end
    cycle(5);
    check("pre_sweep_pos", bus.pos, 6);
    bus.mode = 1;
    for (int k = 0; k < 3; k++) begin
      cycle(1);
      check("sweep_up_pos", bus.pos, upseq[k]);
    end
    bus.mode = 2;
    for (int k = 0; k < 3; k++) begin
      cycle(1);
      check("sweep_dn_pos", bus.pos, dnseq[k]);
    end
    bus.mode = 3;
    for (int k = 0; k < 10; k++) begin
      cycle(1);
      check("hold_pos", bus.pos, 6);
    end
    bus.mode = 1; bus.step_div = 5;
    cycle(3);
    check("div_mid_pos", bus.pos, 6);
    bus.enable = 0;
    cycle(20);
    check("frozen_pos", bus.pos, 6);
    bus.enable = 1;
    cycle(2);
    check("resume_pre_pos", bus.pos, 6);
    cycle(1);
    check("resume_tick_pos", bus.pos, 7);
    cycle(3);
    check("div_change_pre", bus.pos, 7);
    bus.step_div = 1;
    cycle(1);
    check("div_change_tick", bus.pos, 0);
    bus.step_div = 0;
    cycle(5);
    check("pre_clear_pos", bus.pos, 5);
    bus.clear = 1;
    cycle(1);
    bus.clear = 0;
    check("clear_pos", bus.pos, 0);
    check("clear_started", bus.started, 0);
    check("clear_leds", bus.leds, 0);
    cycle(4);
    check("pos3", bus.pos, 3);
`ifdef LED_PATTERN_FADE_EN
    check("pos3_leds", bus.leds, 64'h0F1F3F7FFF7F3F1F);
`else
    check("pos3_leds", bus.leds, 64'h00000000FF000000);
`endif
    cycle(40);
    check("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
